div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative RV32M divider in the EX stage. Executes DIV/DIVU/REM/REMU.
- Sits directly downstream of the forwarding operand muxes. Its operands are the already-forwarded rs1/rs2 values selected by ForwardA/ForwardB.
- Holds the pipeline through stall_o while it iterates. Presents a registered result and destination register for the EX/MEM latch.

Parameters:
- XLEN, 32, operand/result width; even, >= 4.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  EX-stage instruction is a divide op; sampled only in IDLE.
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_data_i  input  XLEN  forwarded dividend.
- rs2_data_i  input  XLEN  forwarded divisor.
- rd_addr_i  input  5  destination register of the divide op.
- flush_i  input  1  kill the in-flight op (branch/exception redirect).
- stall_o  output  1  hold IF/ID/EX; combinational.
- busy_o  output  1  registered; high in CALC.
- done_o  output  1  registered; one-cycle pulse, result valid.
- result_o  output  XLEN  quotient or remainder; registered.
- rd_addr_o  output  5  latched rd_addr_i; registered.

Behaviour:
- Reset: state=IDLE; busy_o=0, done_o=0, result_o=0, rd_addr_o=0, counter=0, internal regs=0. Reset mid-CALC aborts the op with no done_o.
- FSM states: IDLE, CALC, DONE.
- IDLE, start_i=1 and flush_i=0 (accept):
  - Latch op, rd_addr_i, dividend sign, divisor sign.
  - Signed ops take absolute values.
  - Divisor==0 or signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, signed op): load the special result and go to DONE.
  - Otherwise: remainder=0, quotient=|dividend|, counter=XLEN, go to CALC.
- CALC, each cycle (restoring radix-2):
  - {rem,quo} <<= 1; trial = rem - |divisor|.
  - If trial is non-negative: rem=trial, quo[0]=1.
  - counter decrements. When counter reaches 0, go to DONE.
- Entry to DONE: apply sign correction to the registered result.
  - Quotient is negated if the operand signs differ (signed DIV).
  - Remainder takes the dividend's sign (signed REM).
  - result_o = quotient for ops 00/01, remainder for ops 10/11.
- DONE: done_o=1 for exactly one cycle, then IDLE unconditionally. start_i in DONE is ignored.
- Latency, with the accept cycle as T:
  - Normal op: done_o high in cycle T+XLEN+1.
  - Special case: done_o high in cycle T+1.
- Special results:
  - Div by zero: quotient = all ones; remainder = dividend.
  - Overflow: quotient = 0x80000000; remainder = 0.
- stall_o = (IDLE && start_i && !flush_i) || CALC. It is low in DONE, so the pipeline advances and the EX/MEM latch captures result_o/rd_addr_o that cycle.
- start_i while in CALC is ignored; operand inputs are not re-sampled.
- flush_i in any state: go to IDLE next edge. done_o stays 0 (a flush in DONE still leaves the current pulse visible). result_o and rd_addr_o hold their old values.
- flush_i together with start_i in IDLE: not accepted; stall_o=0.
- result_o and rd_addr_o hold the last completed value until the next completion.
- Back-to-back divides: second accept no earlier than the cycle after DONE.

Test Plan:
- DIVU 100/7, rd=5 -> stall_o high T..T+32; done_o only in T+33; result_o=14; rd_addr_o=5.
- DIV -7/2 (0xFFFFFFF9, 2) -> result_o=0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1), dividend sign.
- DIV and REMU with rs2=0, rs1=0x1234 -> done_o at T+1. DIV gives 0xFFFFFFFF; REMU gives 0x1234.
- DIV 0x80000000/0xFFFFFFFF -> done_o at T+1, result_o=0x80000000. REM same operands -> 0.
- Start DIVU, then flush_i at T+10 -> IDLE at T+11, no done_o, result_o unchanged. New DIVU 9/3 accepted at T+11 -> 3 at T+44.
- rst_i asserted in CALC -> next cycle all outputs 0, state IDLE. start_i at T+5 during CALC -> ignored, original result unchanged.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Holds the pipeline via stall_o while iterating and presents a registered result for EX/MEM.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);

  logic [1:0]       state_q;
  logic             op_rem_q;   // 1: result is the remainder
  logic             a_neg_q;    // dividend negative (signed ops only)
  logic             b_neg_q;    // divisor negative (signed ops only)
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       rd_q;

  // Operand preparation at accept time.
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;

  assign is_signed   = ~op_i[0];
  assign a_neg       = is_signed & rs1_data_i[XLEN-1];
  assign b_neg       = is_signed & rs2_data_i[XLEN-1];
  assign abs_a       = a_neg ? -rs1_data_i : rs1_data_i;
  assign abs_b       = b_neg ? -rs2_data_i : rs2_data_i;
  assign div_zero    = (rs2_data_i == '0);
  assign overflow    = is_signed && (rs1_data_i == MIN_NEG) && (rs2_data_i == ALL_ONES);
  assign special_res = div_zero ? (op_i[1] ? rs1_data_i : ALL_ONES)
                                : (op_i[1] ? '0         : MIN_NEG);

  // One restoring step; the extra top bit catches a shifted remainder above XLEN bits.
  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    trial;
  logic [XLEN-1:0]  rem_nxt;
  logic [XLEN-1:0]  quo_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign trial   = rem_sh - {1'b0, dvsr_q};
  assign rem_nxt = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_nxt = {quo_q[XLEN-2:0], ~trial[XLEN]};
  assign cnt_nxt = cnt_q - CNT_W'(1);

  // Sign correction applied on the final step, so the registered result is already fixed up.
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] final_res;

  assign quo_fix   = (a_neg_q ^ b_neg_q) ? -quo_nxt : quo_nxt;
  assign rem_fix   = a_neg_q ? -rem_nxt : rem_nxt;
  assign final_res = op_rem_q ? rem_fix : quo_fix;

  assign stall_o = ((state_q == IDLE) && start_i && !flush_i) || (state_q == CALC);

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values; blocking assignments would create order-dependent logic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_rem_q  <= 1'b0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
        busy_o  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              op_rem_q <= op_i[1];
              a_neg_q  <= a_neg;
              b_neg_q  <= b_neg;
              rd_q     <= rd_addr_i;
              if (div_zero || overflow) begin
                result_o  <= special_res;
                rd_addr_o <= rd_addr_i;
                done_o    <= 1'b1;
                state_q   <= DONE;
              end else begin
                rem_q   <= '0;
                quo_q   <= abs_a;
                dvsr_q  <= abs_b;
                cnt_q   <= CNT_INIT;
                busy_o  <= 1'b1;
                state_q <= CALC;
              end
            end
          end
          CALC: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_nxt;
            if (cnt_nxt == '0) begin
              result_o  <= final_res;
              rd_addr_o <= rd_q;
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
              state_q   <= DONE;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random ops, checked by a
// scoreboard monitor against a plain-arithmetic RV32M reference model.
module tb_div_unit;

  localparam int XLEN = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  always #5 clk_i = ~clk_i;

  div_unit #(.XLEN(XLEN)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M semantics from plain arithmetic; SV signed / and % truncate toward zero.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0)
      r = op[1] ? a : 32'hFFFF_FFFF;
    else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      r = op[1] ? 32'd0 : 32'h8000_0000;
    else begin
      case (op)
        2'b00:   r = 32'($signed(a) / $signed(b));
        2'b01:   r = a / b;
        2'b10:   r = 32'($signed(a) % $signed(b));
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && done_o) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, done_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", result_o, e.res);
        check("rd_addr", {27'b0, rd_addr_o}, {27'b0, e.rd});
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        last_res = e.res;
        last_rd  = e.rd;
      end
    end
  end

  // Called at posedge+1 of the intended accept cycle T; returns at posedge+1 of T+1.
  task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input bit push);
    exp_t e;
    op_i       = op;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_addr_i  = rd;
    start_i    = 1'b1;
    if (push) begin
      e.res = exp_res;
      e.rd  = rd;
      e.cyc = cyc + (is_special(op, a, b) ? 1 : XLEN + 1);
      sb.push_back(e);
    end
    @(negedge clk_i);
    check("accept_stall", {31'b0, stall_o}, 32'd1);
    check("accept_busy", {31'b0, busy_o}, 32'd0);
    check("held_result", result_o, last_res);
    check("held_rd", {27'b0, rd_addr_o}, {27'b0, last_rd});
    @(posedge clk_i);
    #1;
    start_i    = 1'b0;
    op_i       = 2'($urandom);
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    rd_addr_i  = 5'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    bit stall_ok = 1'b1;
    for (int k = 0; k < XLEN + 8; k++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (!stall_o) stall_ok = 1'b0;
    end
    check("done_seen", {31'b0, seen}, 32'd1);
    if (seen) begin
      check("done_stall_low", {31'b0, stall_o}, 32'd0);
      check("calc_stall_high", {31'b0, stall_ok}, 32'd1);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res);
    @(posedge clk_i);
    #1;
    issue_op(op, a, b, rd, exp_res, 1'b1);
    wait_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    op_i = '0; rs1_data_i = '0; rs2_data_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_done", {31'b0, done_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_rd", {27'b0, rd_addr_o}, 32'd0);
    check("reset_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Directed cases with hand-derived results.
    run_op(2'b01, 32'd100, 32'd7, 5'd5, 32'd14);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF);
    run_op(2'b00, 32'h0000_1234, 32'd0, 5'd3, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h0000_1234, 32'd0, 5'd4, 32'h0000_1234);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0);

    // Flush at T+10 kills the op; a new DIVU 9/3 accepted at T+11 completes at T+44.
    @(posedge clk_i);
    #1;
    issue_op(2'b01, 32'hDEAD_BEEF, 32'd13, 5'd9, 32'd0, 1'b0);
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    issue_op(2'b01, 32'd9, 32'd3, 5'd10, 32'd3, 1'b1);
    wait_done();

    // start_i pulsed in CALC at T+5 must be ignored.
    @(posedge clk_i);
    #1;
    issue_op(2'b00, 32'hF000_0123, 32'd77, 5'd11,
             ref_model(2'b00, 32'hF000_0123, 32'd77), 1'b1);
    repeat (4) @(posedge clk_i);
    #1;
    start_i = 1'b1; op_i = 2'b01; rs1_data_i = 32'd5; rs2_data_i = 32'd0; rd_addr_i = 5'd30;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_done();

    // Synchronous reset in CALC aborts the op and clears outputs.
    @(posedge clk_i);
    #1;
    issue_op(2'b11, 32'h1234_5678, 32'd99, 5'd12, 32'd0, 1'b0);
    repeat (4) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midreset_busy", {31'b0, busy_o}, 32'd0);
    check("midreset_done", {31'b0, done_o}, 32'd0);
    check("midreset_result", result_o, 32'd0);
    check("midreset_rd", {27'b0, rd_addr_o}, 32'd0);
    check("midreset_stall", {31'b0, stall_o}, 32'd0);
    last_res = '0;
    last_rd  = '0;
    repeat (XLEN + 4) @(posedge clk_i);

    // start_i with flush_i in IDLE is not accepted.
    #1;
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; rs1_data_i = 32'd50; rs2_data_i = 32'd5;
    @(negedge clk_i);
    check("flush_start_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk_i);
    #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_start_busy", {31'b0, busy_o}, 32'd0);
    repeat (3) @(posedge clk_i);

    // Random ops biased towards zero/small/-1 divisors and the most negative dividend.
    for (int n = 0; n < 30; n++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(op, a, b, 5'($urandom), ref_model(op, a, b));
    end

    repeat (5) @(posedge clk_i);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
